ssd_capture: RTL and testbench

//  Receive-side monitor for a multiplexed 7-segment display bus (active-low segments, active-low digit anodes).

---
 rtl/ssd_pkg.sv | 47 ++++
 rtl/ssd2hex.sv | 42 ++++
 rtl/ssd_capture.sv | 166 ++++++++++++++++
 tb/tb_ssd_capture.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants and types for the 7-segment display capture block.
//   SSD_BLANK        all segments dark (active-low bus)
//   SSD_GLYPH_0..F   canonical active-low glyphs, bit0=a .. bit6=g
//   SSD_ALT_GLYPH_*  alternate 7/9 shapes, decoded only with SSD_CAPTURE_ALT_GLYPH_EN
//   ssd_state_e      capture FSM states
//   ssd_event_t      one captured digit event {digit, hex, err}
package ssd_pkg;

    localparam logic [6:0] SSD_BLANK   = 7'h7F;

    localparam logic [6:0] SSD_GLYPH_0 = 7'h40;
    localparam logic [6:0] SSD_GLYPH_1 = 7'h79;
    localparam logic [6:0] SSD_GLYPH_2 = 7'h24;
    localparam logic [6:0] SSD_GLYPH_3 = 7'h30;
    localparam logic [6:0] SSD_GLYPH_4 = 7'h19;
    localparam logic [6:0] SSD_GLYPH_5 = 7'h12;
    localparam logic [6:0] SSD_GLYPH_6 = 7'h02;
    localparam logic [6:0] SSD_GLYPH_7 = 7'h78;
    localparam logic [6:0] SSD_GLYPH_8 = 7'h00;
    localparam logic [6:0] SSD_GLYPH_9 = 7'h18;
    localparam logic [6:0] SSD_GLYPH_A = 7'h08;
    localparam logic [6:0] SSD_GLYPH_B = 7'h03;
    localparam logic [6:0] SSD_GLYPH_C = 7'h46;
    localparam logic [6:0] SSD_GLYPH_D = 7'h21;
    localparam logic [6:0] SSD_GLYPH_E = 7'h06;
    localparam logic [6:0] SSD_GLYPH_F = 7'h0E;

    // Alternate shapes: 7 with segment f lit, 9 with segment d lit.
    localparam logic [6:0] SSD_ALT_GLYPH_7 = 7'h58;
    localparam logic [6:0] SSD_ALT_GLYPH_9 = 7'h10;

    // Event digit field is sized for the largest supported display (256 digits).
    localparam int SSD_IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } ssd_state_e;

    typedef struct packed {
        logic [SSD_IDX_W-1:0] digit;
        logic [3:0]           hex;
        logic                 err;
    } ssd_event_t;

endpackage

// File: rtl/ssd2hex.sv
// ssd2hex: combinational decoder from an active-low 7-segment pattern to a hex nibble.
//   seg_i  in  7  segment pattern, bit0=a .. bit6=g, 0=lit
//   hex_o  out 4  decoded nibble, 0 when the pattern is not a known glyph
//   err_o  out 1  pattern not in the decode table
// Build option: SSD_CAPTURE_ALT_GLYPH_EN adds the alternate 7 (7'h58) and 9 (7'h10) shapes.
module ssd2hex
    import ssd_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] hex_o,
    output logic       err_o
);

    always_comb begin
        hex_o = 4'h0;
        err_o = 1'b0;
        case (seg_i)
            SSD_GLYPH_0: hex_o = 4'h0;
            SSD_GLYPH_1: hex_o = 4'h1;
            SSD_GLYPH_2: hex_o = 4'h2;
            SSD_GLYPH_3: hex_o = 4'h3;
            SSD_GLYPH_4: hex_o = 4'h4;
            SSD_GLYPH_5: hex_o = 4'h5;
            SSD_GLYPH_6: hex_o = 4'h6;
            SSD_GLYPH_7: hex_o = 4'h7;
            SSD_GLYPH_8: hex_o = 4'h8;
            SSD_GLYPH_9: hex_o = 4'h9;
            SSD_GLYPH_A: hex_o = 4'hA;
            SSD_GLYPH_B: hex_o = 4'hB;
            SSD_GLYPH_C: hex_o = 4'hC;
            SSD_GLYPH_D: hex_o = 4'hD;
            SSD_GLYPH_E: hex_o = 4'hE;
            SSD_GLYPH_F: hex_o = 4'hF;
`ifdef SSD_CAPTURE_ALT_GLYPH_EN
            SSD_ALT_GLYPH_7: hex_o = 4'h7;
            SSD_ALT_GLYPH_9: hex_o = 4'h9;
`endif
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ssd_capture.sv
// ssd_capture: receive-side monitor for a multiplexed 7-segment display bus.
// Samples segment/anode lines, waits for STABLE_CYCLES identical samples, decodes the
// settled glyph and emits one event per settled digit on a one-deep valid/ready output.
// A per-digit shadow keeps the last successfully decoded nibble of every digit.
//   clk_i       in   1                   clock, rising edge
//   reset_i     in   1                   asynchronous active-high reset
//   ssd_i       in   7                   segments, active-low, bit0=a .. bit6=g
//   an_i        in   NUM_DIGITS          digit enables, active-low, valid when exactly one is 0
//   valid_o     out  1                   event available
//   ready_i     in   1                   consumer takes the event when valid_o && ready_i
//   digit_o     out  $clog2(NUM_DIGITS)  digit index of the event
//   hex_o       out  4                   decoded nibble (0 when err_o)
//   err_o       out  1                   settled glyph not decodable
//   overflow_o  out  1                   sticky, an event was dropped
//   digits_o    out  4*NUM_DIGITS        shadow, digit i at [4i+3:4i]
// Build option: SSD_CAPTURE_ALT_GLYPH_EN (forwarded to ssd2hex) enables alternate 7/9 glyphs.
//
// state  | meaning
// IDLE   | sample blank or anodes not one-hot, nothing to capture
// SETTLE | valid sample, counting identical samples
// LOCKED | event for the current sample already emitted
module ssd_capture
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [6:0]              ssd_i,
    input  logic [NUM_DIGITS-1:0]   an_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [IDX_W-1:0]        digit_o,
    output logic [3:0]              hex_o,
    output logic                    err_o,
    output logic                    overflow_o,
    output logic [4*NUM_DIGITS-1:0] digits_o
);

    localparam int SAMP_W = NUM_DIGITS + 7;
    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_DONE   = CNT_W'(STABLE_CYCLES);
    localparam logic [SAMP_W-1:0] SAMP_RESET = {{NUM_DIGITS{1'b1}}, SSD_BLANK};

    logic [SAMP_W-1:0]       samp_q, samp_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    ssd_state_e              state_q, state_d;
    ssd_event_t              ev_q, ev_d;
    logic                    valid_q, valid_d;
    logic                    ovf_q, ovf_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;

    logic                    changed;
    logic                    seen_one;
    logic                    seen_many;
    logic                    sample_ok;
    logic                    emit;
    logic [IDX_W-1:0]        idx;
    logic [3:0]              dec_hex;
    logic                    dec_err;

    ssd2hex u_ssd2hex (
        .seg_i (ssd_i),
        .hex_o (dec_hex),
        .err_o (dec_err)
    );

    always_comb begin
        samp_d  = {an_i, ssd_i};
        changed = (samp_d != samp_q);

        if (changed) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q < CNT_DONE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        seen_one  = 1'b0;
        seen_many = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_i[i]) begin
                if (seen_one) begin
                    seen_many = 1'b1;
                end
                seen_one = 1'b1;
                idx      = IDX_W'(i);
            end
        end
        sample_ok = seen_one && !seen_many && (ssd_i != SSD_BLANK);

        // The counter saturates once settled, so LOCKED suppresses repeats of the same sample;
        // a fresh change is let through so STABLE_CYCLES=1 emits on the first sample.
        emit = sample_ok && (cnt_d == CNT_DONE) && (changed || state_q != LOCKED);

        if (!sample_ok) begin
            state_d = IDLE;
        end else if (emit) begin
            state_d = LOCKED;
        end else if (changed || state_q == IDLE) begin
            state_d = SETTLE;
        end else begin
            state_d = state_q;
        end

        ev_d    = ev_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (emit) begin
            if (!valid_q || ready_i) begin
                ev_d.digit = SSD_IDX_W'(idx);
                ev_d.hex   = dec_hex;
                ev_d.err   = dec_err;
                valid_d    = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        // Shadow tracks what the display showed, whether or not the consumer took the event.
        digits_d = digits_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (emit && !dec_err && idx == IDX_W'(i)) begin
                digits_d[4*i +: 4] = dec_hex;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            samp_q   <= SAMP_RESET;
            cnt_q    <= '0;
            state_q  <= IDLE;
            ev_q     <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            digits_q <= '0;
        end else begin
            samp_q   <= samp_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            ev_q     <= ev_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            digits_q <= digits_d;
        end
    end

    // Upper event-digit bits are always zero for this display size.
    logic unused_digit_bits;
    assign unused_digit_bits = ^ev_q.digit;

    assign valid_o    = valid_q;
    assign digit_o    = ev_q.digit[IDX_W-1:0];
    assign hex_o      = ev_q.hex;
    assign err_o      = ev_q.err;
    assign overflow_o = ovf_q;
    assign digits_o   = digits_q;

endmodule

// File: tb/tb_ssd_capture.sv
`timescale 1ns/1ps
module tb_ssd_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [6:0]    ssd_i;
    logic [ND-1:0] an_i;
    logic          ready_i;
    logic          valid_o;
    logic [1:0]    digit_o;
    logic [3:0]    hex_o;
    logic          err_o;
    logic          overflow_o;
    logic [4*ND-1:0] digits_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    ssd_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .ssd_i      (ssd_i),
        .an_i       (an_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .digit_o    (digit_o),
        .hex_o      (hex_o),
        .err_o      (err_o),
        .overflow_o (overflow_o),
        .digits_o   (digits_o)
    );

    // Reference model: run length of identical samples plus a one-deep output slot.
    logic [ND+6:0]   m_prev;
    int              m_run;
    logic            m_valid;
    logic [1:0]      m_digit;
    logic [3:0]      m_hex;
    logic            m_err;
    logic            m_ovf;
    logic [4*ND-1:0] m_shadow;
    logic [6:0]      glyph_tab [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (glyph_tab[i] == s) return {1'b0, 4'(i)};
        end
`ifdef SSD_CAPTURE_ALT_GLYPH_EN
        if (s == 7'h58) return {1'b0, 4'h7};
        if (s == 7'h10) return {1'b0, 4'h9};
`endif
        return {1'b1, 4'h0};
    endfunction

    task automatic model_reset();
        m_prev   = {{ND{1'b1}}, 7'h7F};
        m_run    = 0;
        m_valid  = 1'b0;
        m_digit  = '0;
        m_hex    = '0;
        m_err    = 1'b0;
        m_ovf    = 1'b0;
        m_shadow = '0;
    endtask

    task automatic model_edge();
        logic [ND+6:0] s;
        logic [4:0]    dec;
        logic          emit;
        int            zeros;
        int            idx;
        s = {an_i, ssd_i};
        if (s == m_prev) m_run++;
        else m_run = 1;
        m_prev = s;
        zeros = 0;
        idx   = 0;
        for (int i = 0; i < ND; i++) begin
            if (!an_i[i]) begin
                zeros++;
                idx = i;
            end
        end
        emit = (zeros == 1) && (ssd_i != 7'h7F) && (m_run == SC);
        dec  = ref_decode(ssd_i);
        if (emit) begin
            if (!m_valid || ready_i) begin
                m_valid = 1'b1;
                m_digit = 2'(idx);
                m_hex   = dec[3:0];
                m_err   = dec[4];
            end else begin
                m_ovf = 1'b1;
            end
            if (!dec[4]) m_shadow[idx*4 +: 4] = dec[3:0];
        end else if (m_valid && ready_i) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_model();
        check("model_valid", 32'(valid_o), 32'(m_valid));
        if (m_valid) begin
            check("model_digit", 32'(digit_o), 32'(m_digit));
            check("model_hex", 32'(hex_o), 32'(m_hex));
            check("model_err", 32'(err_o), 32'(m_err));
        end
        check("model_overflow", 32'(overflow_o), 32'(m_ovf));
        check("model_digits", 32'(digits_o), 32'(m_shadow));
    endtask

    // Advance one clock; inputs are only changed at posedge+1 so the edge sees stable values.
    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    typedef struct {
        logic [3:0] an;
        logic [6:0] ssd;
        logic       exp_valid;
        logic [1:0] exp_digit;
        logic [3:0] exp_hex;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int   ev_count;
        logic bad_seen;

        glyph_tab[0]  = 7'h40; glyph_tab[1]  = 7'h79; glyph_tab[2]  = 7'h24; glyph_tab[3]  = 7'h30;
        glyph_tab[4]  = 7'h19; glyph_tab[5]  = 7'h12; glyph_tab[6]  = 7'h02; glyph_tab[7]  = 7'h78;
        glyph_tab[8]  = 7'h00; glyph_tab[9]  = 7'h18; glyph_tab[10] = 7'h08; glyph_tab[11] = 7'h03;
        glyph_tab[12] = 7'h46; glyph_tab[13] = 7'h21; glyph_tab[14] = 7'h06; glyph_tab[15] = 7'h0E;

        vecs.push_back('{4'b1110, 7'h30, 1'b1, 2'd0, 4'h3, 1'b0});
        vecs.push_back('{4'b1011, 7'h0E, 1'b1, 2'd2, 4'hF, 1'b0});
        vecs.push_back('{4'b0111, 7'h40, 1'b1, 2'd3, 4'h0, 1'b0});
        vecs.push_back('{4'b1101, 7'h79, 1'b1, 2'd1, 4'h1, 1'b0});
        vecs.push_back('{4'b1110, 7'h08, 1'b1, 2'd0, 4'hA, 1'b0});
        vecs.push_back('{4'b1101, 7'h21, 1'b1, 2'd1, 4'hD, 1'b0});
        vecs.push_back('{4'b1110, 7'h55, 1'b1, 2'd0, 4'h0, 1'b1});
`ifdef SSD_CAPTURE_ALT_GLYPH_EN
        vecs.push_back('{4'b1011, 7'h58, 1'b1, 2'd2, 4'h7, 1'b0});
        vecs.push_back('{4'b0111, 7'h10, 1'b1, 2'd3, 4'h9, 1'b0});
`else
        vecs.push_back('{4'b1011, 7'h58, 1'b1, 2'd2, 4'h0, 1'b1});
        vecs.push_back('{4'b0111, 7'h10, 1'b1, 2'd3, 4'h0, 1'b1});
`endif
        vecs.push_back('{4'b1011, 7'h7F, 1'b0, 2'd0, 4'h0, 1'b0});
        vecs.push_back('{4'b1100, 7'h30, 1'b0, 2'd0, 4'h0, 1'b0});
        vecs.push_back('{4'b1111, 7'h30, 1'b0, 2'd0, 4'h0, 1'b0});

        // Reset state, then first-event latency.
        an_i = 4'b1110; ssd_i = 7'h30; ready_i = 1'b1;
        do_reset();
        check("rst_valid", 32'(valid_o), 0);
        check("rst_overflow", 32'(overflow_o), 0);
        check("rst_digits", 32'(digits_o), 0);
        check("rst_hex", 32'(hex_o), 0);
        for (int c = 0; c < SC - 1; c++) begin
            step();
            check("lat_no_valid", 32'(valid_o), 0);
        end
        step();
        check("lat_valid", 32'(valid_o), 1);
        check("lat_digit", 32'(digit_o), 0);
        check("lat_hex", 32'(hex_o), 3);
        check("lat_err", 32'(err_o), 0);

        // Held digit produces exactly one event.
        an_i = 4'b1011; ssd_i = 7'h0E; ready_i = 1'b1;
        ev_count = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (valid_o && digit_o == 2'd2) ev_count++;
        end
        check("held_one_event", 32'(ev_count), 1);
        check("held_shadow", 32'(digits_o[11:8]), 32'hF);

        // Short glitch on digit 0 leaves no trace.
        an_i = 4'b1110; ssd_i = 7'h40;
        repeat (SC + 1) step();
        bad_seen = 1'b0;
        ssd_i = 7'h79;
        repeat (2) begin step(); if (valid_o && hex_o == 4'h1) bad_seen = 1'b1; end
        ssd_i = 7'h40;
        repeat (SC + 2) begin step(); if (valid_o && hex_o == 4'h1) bad_seen = 1'b1; end
        check("glitch_no_event", 32'(bad_seen), 0);
        check("glitch_shadow", 32'(digits_o), 32'h0F00);

        // Blank and non-one-hot inputs never emit.
        step();
        ev_count = 0;
        an_i = 4'b1110; ssd_i = 7'h7F;
        repeat (10) begin step(); if (valid_o) ev_count++; end
        an_i = 4'b1100; ssd_i = 7'h30;
        repeat (10) begin step(); if (valid_o) ev_count++; end
        check("invalid_no_event", 32'(ev_count), 0);

        // Table-driven vectors, each from a blank bus.
        foreach (vecs[v]) begin
            an_i = '1; ssd_i = 7'h7F; ready_i = 1'b1;
            step(); step();
            an_i = vecs[v].an; ssd_i = vecs[v].ssd;
            for (int c = 0; c < SC; c++) begin
                step();
                if (c == SC - 2) check("tbl_early", 32'(valid_o), 0);
            end
            check("tbl_valid", 32'(valid_o), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                check("tbl_digit", 32'(digit_o), 32'(vecs[v].exp_digit));
                check("tbl_hex", 32'(hex_o), 32'(vecs[v].exp_hex));
                check("tbl_err", 32'(err_o), 32'(vecs[v].exp_err));
            end
        end

        // Back-pressure: second event dropped, shadow still updated.
        do_reset();
        ready_i = 1'b0;
        an_i = 4'b1110; ssd_i = 7'h24;
        repeat (SC) step();
        check("bp_first_valid", 32'(valid_o), 1);
        check("bp_first_hex", 32'(hex_o), 2);
        an_i = 4'b1101; ssd_i = 7'h12;
        repeat (SC) step();
        check("bp_overflow", 32'(overflow_o), 1);
        check("bp_held_hex", 32'(hex_o), 2);
        check("bp_held_digit", 32'(digit_o), 0);
        check("bp_shadow1", 32'(digits_o[7:4]), 5);
        check("bp_shadow0", 32'(digits_o[3:0]), 2);

        // Asynchronous reset in the middle of settling.
        an_i = 4'b1011; ssd_i = 7'h58;
        step(); step();
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_valid", 32'(valid_o), 0);
        check("arst_overflow", 32'(overflow_o), 0);
        check("arst_digits", 32'(digits_o), 0);
        check("arst_hex", 32'(hex_o), 0);
        check("arst_err", 32'(err_o), 0);
        check("arst_digit", 32'(digit_o), 0);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        // Alternate 7 after reset.
        ready_i = 1'b1;
        repeat (SC) step();
        check("alt7_valid", 32'(valid_o), 1);
`ifdef SSD_CAPTURE_ALT_GLYPH_EN
        check("alt7_hex", 32'(hex_o), 7);
        check("alt7_err", 32'(err_o), 0);
`else
        check("alt7_hex", 32'(hex_o), 0);
        check("alt7_err", 32'(err_o), 1);
`endif

        // Randomized bus activity against the model.
        for (int n = 0; n < 120; n++) begin
            int hold;
            int kind;
            if (n == 60) do_reset();
            hold = $urandom_range(1, 7);
            kind = $urandom_range(0, 9);
            if (kind < 8) an_i = ~(4'b0001 << $urandom_range(0, 3));
            else an_i = 4'($urandom);
            kind = $urandom_range(0, 9);
            if (kind < 7) ssd_i = glyph_tab[$urandom_range(0, 15)];
            else if (kind == 7) ssd_i = 7'h7F;
            else if (kind == 8) ssd_i = ($urandom_range(0, 1) != 0) ? 7'h58 : 7'h10;
            else ssd_i = 7'($urandom);
            for (int h = 0; h < hold; h++) begin
                ready_i = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
